// File: rtl/apb_master_bridge.sv
// rtl/apb_master_bridge.sv - req/gnt/rvalid data port to APB3 master, one transfer in flight.
// Optional ACCESS wait-state timeout enabled by defining APB_MASTER_TIMEOUT_EN.
module apb_master_bridge #(
  parameter int unsigned APB_ADDR_WIDTH = 32,
  parameter int unsigned APB_DATA_WIDTH = 32,
  parameter int unsigned TIMEOUT_CYCLES = 256
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic                          req_i,
  input  logic                          we_i,
  input  logic [APB_ADDR_WIDTH-1:0]     addr_i,
  input  logic [APB_DATA_WIDTH/8-1:0]   be_i,
  input  logic [APB_DATA_WIDTH-1:0]     wdata_i,
  output logic                          gnt_o,
  output logic                          rvalid_o,
  output logic [APB_DATA_WIDTH-1:0]     rdata_o,
  output logic                          err_o,
  output logic [APB_ADDR_WIDTH-1:0]     paddr_o,
  output logic [APB_DATA_WIDTH-1:0]     pwdata_o,
  output logic                          pwrite_o,
  output logic                          psel_o,
  output logic                          penable_o,
  input  logic [APB_DATA_WIDTH-1:0]     prdata_i,
  input  logic                          pready_i,
  input  logic                          pslverr_i
);

  if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
    $error("apb_master_bridge: TIMEOUT_CYCLES must be in 1..65535");
  end

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_e;

  state_e                      state_q, state_d;
  logic                        psel_q, psel_d;
  logic                        penable_q, penable_d;
  logic                        pwrite_q, pwrite_d;
  logic [APB_ADDR_WIDTH-1:0]   paddr_q, paddr_d;
  logic [APB_DATA_WIDTH-1:0]   pwdata_q, pwdata_d;
  logic                        rvalid_q, rvalid_d;
  logic [APB_DATA_WIDTH-1:0]   rdata_q, rdata_d;
  logic                        err_q, err_d;

`ifdef APB_MASTER_TIMEOUT_EN
  localparam logic [15:0] TIMEOUT_LAST = 16'(TIMEOUT_CYCLES - 1);
  logic [15:0] wait_cnt_q, wait_cnt_d;
`endif

  always_comb begin
    state_d   = state_q;
    psel_d    = psel_q;
    penable_d = penable_q;
    pwrite_d  = pwrite_q;
    paddr_d   = paddr_q;
    pwdata_d  = pwdata_q;
    rvalid_d  = 1'b0;
    rdata_d   = rdata_q;
    err_d     = err_q;
`ifdef APB_MASTER_TIMEOUT_EN
    wait_cnt_d = wait_cnt_q;
`endif
    case (state_q)
      IDLE: begin
        if (req_i) begin
          paddr_d  = addr_i;
          pwrite_d = we_i;
          pwdata_d = wdata_i;
          // APB3 has no byte strobes, so a partial write is refused without touching the bus
          if (we_i && !(&be_i)) begin
            state_d  = RESP;
            rvalid_d = 1'b1;
            err_d    = 1'b1;
            rdata_d  = '0;
          end else begin
            state_d = SETUP;
            psel_d  = 1'b1;
          end
        end
      end
      SETUP: begin
        state_d   = ACCESS;
        penable_d = 1'b1;
`ifdef APB_MASTER_TIMEOUT_EN
        wait_cnt_d = '0;
`endif
      end
      ACCESS: begin
        if (pready_i) begin
          state_d   = RESP;
          psel_d    = 1'b0;
          penable_d = 1'b0;
          rvalid_d  = 1'b1;
          err_d     = pslverr_i;
          rdata_d   = pwrite_q ? '0 : prdata_i;
        end
`ifdef APB_MASTER_TIMEOUT_EN
        else if (wait_cnt_q == TIMEOUT_LAST) begin
          state_d   = RESP;
          psel_d    = 1'b0;
          penable_d = 1'b0;
          rvalid_d  = 1'b1;
          err_d     = 1'b1;
          rdata_d   = '0;
        end else begin
          wait_cnt_d = wait_cnt_q + 16'd1;
        end
`endif
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= IDLE;
      psel_q    <= 1'b0;
      penable_q <= 1'b0;
      pwrite_q  <= 1'b0;
      paddr_q   <= '0;
      pwdata_q  <= '0;
      rvalid_q  <= 1'b0;
      rdata_q   <= '0;
      err_q     <= 1'b0;
`ifdef APB_MASTER_TIMEOUT_EN
      wait_cnt_q <= '0;
`endif
    end else begin
      state_q   <= state_d;
      psel_q    <= psel_d;
      penable_q <= penable_d;
      pwrite_q  <= pwrite_d;
      paddr_q   <= paddr_d;
      pwdata_q  <= pwdata_d;
      rvalid_q  <= rvalid_d;
      rdata_q   <= rdata_d;
      err_q     <= err_d;
`ifdef APB_MASTER_TIMEOUT_EN
      wait_cnt_q <= wait_cnt_d;
`endif
    end
  end

  assign gnt_o     = req_i & (state_q == IDLE) & ~rst_i;
  assign rvalid_o  = rvalid_q;
  assign rdata_o   = rdata_q;
  assign err_o     = err_q;
  assign paddr_o   = paddr_q;
  assign pwdata_o  = pwdata_q;
  assign pwrite_o  = pwrite_q;
  assign psel_o    = psel_q;
  assign penable_o = penable_q;

endmodule
